pacman_soc_otg_hpi_bridge: RTL

Avalon-MM slave that turns single CPU register accesses into complete, correctly timed CY7C67200 HPI bus cycles. It sits downstream of the OTG HPI PIO registers (address/data/cs/rd/wr), so software issues one read or write instead of bit-banging each strobe. It drives the USB controller pins directly; the top level resolves the 16-bit tristate bus.

---
 rtl/pacman_soc_otg_hpi_bridge.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/pacman_soc_otg_hpi_bridge.sv
// pacman_soc_otg_hpi_bridge
// Avalon-MM slave that turns one CPU register access into a complete,
// timed CY7C67200 HPI bus cycle (setup / strobe / hold / done).
// Optional feature macro: OTG_HPI_IRQ_EN. When defined, otg_int is
// synchronised and its rising edge latches irq. A read of the STATUS
// register (address 3) clears irq. When undefined, irq is tied low.
//
// state  | meaning
// IDLE   | waiting for a request; latches address, data and direction
// SETUP  | CS_n low, address/data valid, strobes high
// STROBE | RD_n or WR_n low; reads sample the bus on the last cycle
// HOLD   | strobes high, CS_n/address/data still held
// DONE   | CS_n high, waitrequest released for one cycle
module pacman_soc_otg_hpi_bridge #(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        irq,
  output logic [1:0]  otg_addr,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  input  logic [15:0] otg_data_in,
  input  logic        otg_int
);

  localparam int unsigned MAX_AB = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int unsigned MAX_P  = (MAX_AB > HOLD_CYCLES) ? MAX_AB : HOLD_CYCLES;
  localparam int unsigned CW     = (MAX_P > 1) ? $clog2(MAX_P + 1) : 1;

  localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_write_q, is_write_d;
  logic [1:0]    otg_addr_q, otg_addr_d;
  logic [15:0]   otg_data_out_q, otg_data_out_d;
  logic          otg_cs_n_q, otg_cs_n_d;
  logic          otg_rd_n_q, otg_rd_n_d;
  logic          otg_wr_n_q, otg_wr_n_d;
  logic          otg_data_oe_q, otg_data_oe_d;
  logic [15:0]   readdata_q, readdata_d;

  logic req;
  logic cnt_done;
  logic active;

  // Request decode; a request with both strobes low is treated as a write.
  always_comb begin
    req      = chipselect & (~read_n | ~write_n);
    cnt_done = (cnt_q == '0);
  end

  assign waitrequest = req & (state_q != ST_DONE);

  // State and counter register; every HPI pin comes straight from a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      is_write_q     <= 1'b0;
      otg_addr_q     <= 2'd0;
      otg_data_out_q <= 16'd0;
      otg_cs_n_q     <= 1'b1;
      otg_rd_n_q     <= 1'b1;
      otg_wr_n_q     <= 1'b1;
      otg_data_oe_q  <= 1'b0;
      readdata_q     <= 16'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      is_write_q     <= is_write_d;
      otg_addr_q     <= otg_addr_d;
      otg_data_out_q <= otg_data_out_d;
      otg_cs_n_q     <= otg_cs_n_d;
      otg_rd_n_q     <= otg_rd_n_d;
      otg_wr_n_q     <= otg_wr_n_d;
      otg_data_oe_q  <= otg_data_oe_d;
      readdata_q     <= readdata_d;
    end
  end

  // Next-state: each phase is timed by one down-counter reloaded on entry.
  // Once started, a cycle always runs to DONE even if the request drops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_done) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_done) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_done) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: pin values are derived from the upcoming state so they change
  // on the same edge as the state register, keeping the strobes glitch-free.
  always_comb begin
    is_write_d     = is_write_q;
    otg_addr_d     = otg_addr_q;
    otg_data_out_d = otg_data_out_q;
    readdata_d     = readdata_q;

    if ((state_q == ST_IDLE) && req) begin
      is_write_d = ~write_n;
      otg_addr_d = address;
      if (!write_n) begin
        otg_data_out_d = writedata[15:0];
      end
    end

    active = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);

    otg_cs_n_d    = ~active;
    otg_data_oe_d = active & is_write_d;
    otg_rd_n_d    = ~((state_d == ST_STROBE) & ~is_write_d);
    otg_wr_n_d    = ~((state_d == ST_STROBE) &  is_write_d);

    if ((state_q == ST_STROBE) && cnt_done && !is_write_q) begin
      readdata_d = otg_data_in;
    end
  end

  assign otg_addr     = otg_addr_q;
  assign otg_data_out = otg_data_out_q;
  assign otg_cs_n     = otg_cs_n_q;
  assign otg_rd_n     = otg_rd_n_q;
  assign otg_wr_n     = otg_wr_n_q;
  assign otg_data_oe  = otg_data_oe_q;
  assign readdata     = {16'd0, readdata_q};

  logic unused_bits;

`ifdef OTG_HPI_IRQ_EN
  logic int_meta_q, int_sync_q, int_prev_q;
  logic irq_q, irq_d;
  logic irq_set, irq_clr;

  // Interrupt latch: set on a synchronised rising edge, cleared by a STATUS
  // read completing; a simultaneous set wins so no edge is lost.
  always_comb begin
    irq_set = int_sync_q & ~int_prev_q;
    irq_clr = (state_q == ST_DONE) & ~is_write_q & (otg_addr_q == 2'd3);
    irq_d   = irq_set | (irq_q & ~irq_clr);
  end

  // Two-flop synchroniser plus edge-detect history and the irq flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_meta_q <= 1'b0;
      int_sync_q <= 1'b0;
      int_prev_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      int_meta_q <= otg_int;
      int_sync_q <= int_meta_q;
      int_prev_q <= int_sync_q;
      irq_q      <= irq_d;
    end
  end

  assign irq         = irq_q;
  assign unused_bits = ^writedata[31:16];
`else
  assign irq         = 1'b0;
  assign unused_bits = ^{writedata[31:16], otg_int};
`endif

endmodule
